// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_pkg
//  Description : Shared ALU op encodings, M-stage FSM state type and helper
//                decode functions for the pipeline memory stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    // 6-bit ALU op encoding shared with execute
    localparam logic [5:0] c_OP_ADD = 6'b000000;
    localparam logic [5:0] c_OP_LW  = 6'b010011;
    localparam logic [5:0] c_OP_SW  = 6'b010100;
    localparam logic [5:0] c_OP_LB  = 6'b010101;
    localparam logic [5:0] c_OP_LUI = 6'b010110;
    localparam logic [5:0] c_OP_SB  = 6'b010111;
    localparam logic [5:0] c_OP_LBU = 6'b011000;

    // M-stage FSM encoding
    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_e;

    // Any op that touches data memory
    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == c_OP_LW) || (op == c_OP_SW) || (op == c_OP_LB) ||
               (op == c_OP_LBU) || (op == c_OP_SB);
    endfunction

    // Word-sized accesses, which must be 4-byte aligned
    function automatic logic is_word_op(input logic [5:0] op);
        return (op == c_OP_LW) || (op == c_OP_SW);
    endfunction

    // Byte-sized accesses, which use a single byte lane
    function automatic logic is_byte_op(input logic [5:0] op);
        return (op == c_OP_LB) || (op == c_OP_LBU) || (op == c_OP_SB);
    endfunction

endpackage : mem_stage_pkg
`default_nettype wire

// File: rtl/mem_stage_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_align
//  Description : Selects the addressed byte of a big-endian memory word and
//                sign/zero-extends it for LB/LBU; LW passes the word through.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [5:0]  i_op,
    output logic [31:0] o_data
);

    logic [7:0] w_byte;

    // Byte lane select: offset 0 is the most significant byte
    always_comb begin
        w_byte = i_rdata[31:24];
        case (i_offset)
            2'd0:    w_byte = i_rdata[31:24];
            2'd1:    w_byte = i_rdata[23:16];
            2'd2:    w_byte = i_rdata[15:8];
            default: w_byte = i_rdata[7:0];
        endcase
    end

    // Extension according to load type
    always_comb begin
        o_data = i_rdata;
        if (i_op == c_OP_LB) begin
            o_data = {{24{w_byte[7]}}, w_byte};
        end else if (i_op == c_OP_LBU) begin
            o_data = {24'd0, w_byte};
        end
    end

endmodule : load_align
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Pipeline memory stage. Holds the X/M payload, runs the
//                data-memory req/ready handshake with byte lanes, produces
//                writeback data and the MX bypass, and stalls upstream while
//                an access is outstanding.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
)(
    input  logic        clock,
    input  logic        resetn,
    input  logic        x_valid,
    input  logic [31:0] x_aluout,
    input  logic [31:0] x_rbout,
    input  logic [5:0]  x_aluop,
    input  logic        x_dmwe,
    input  logic        x_rwe,
    input  logic        x_rwd,
    input  logic [4:0]  x_rdst,
    output logic        stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ready,
    output logic [31:0] mx_bypass,
    output logic [4:0]  m_rdst,
    output logic        m_rwe,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rdst,
    output logic        wb_rwe,
    output logic        misalign,
    output logic        bus_err
);

    localparam int              c_CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    // M register
    logic        r_m_valid;
    logic [31:0] r_m_aluout;
    logic [31:0] r_m_rbout;
    logic [5:0]  r_m_aluop;
    logic        r_m_dmwe;
    logic        r_m_rwe;
    logic        r_m_rwd;
    logic [4:0]  r_m_rdst;

    state_e          r_state;
    state_e          w_state_nxt;
    logic [c_CW-1:0] r_cnt;

    logic        r_wb_valid;
    logic [31:0] r_wb_data;
    logic [4:0]  r_wb_rdst;
    logic        r_wb_rwe;
    logic        r_misalign;
    logic        r_bus_err;

    logic        w_stall;
    logic        w_timeout;
    logic        w_x_access;
    logic        w_m_misal;
    logic        w_m_done;
    logic [31:0] w_load_data;

    // Incoming insn will need a real bus access (aligned mem op)
    assign w_x_access = x_valid && is_mem_op(x_aluop) &&
                        !(is_word_op(x_aluop) && (x_aluout[1:0] != 2'b00));

    // Registered insn is a misaligned word access; it retires without a bus cycle
    assign w_m_misal = r_m_valid && is_word_op(r_m_aluop) && (r_m_aluout[1:0] != 2'b00);

    // Last permitted ACCESS cycle passed without ready; ready on the same cycle wins
    assign w_timeout = (TIMEOUT != 0) && (r_state == S_ACCESS) && !dm_ready &&
                       (r_cnt == c_CNT_LAST);

    assign w_stall  = (r_state == S_ACCESS) && !dm_ready && !w_timeout;
    assign w_m_done = r_m_valid && ((r_state == S_IDLE) || dm_ready || w_timeout);

    // M register: advances whenever the stage is not stalled
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_m_valid  <= 1'b0;
            r_m_aluout <= 32'd0;
            r_m_rbout  <= 32'd0;
            r_m_aluop  <= 6'd0;
            r_m_dmwe   <= 1'b0;
            r_m_rwe    <= 1'b0;
            r_m_rwd    <= 1'b0;
            r_m_rdst   <= 5'd0;
        end else if (!w_stall) begin
            r_m_valid  <= x_valid;
            r_m_aluout <= x_aluout;
            r_m_rbout  <= x_rbout;
            r_m_aluop  <= x_aluop;
            r_m_dmwe   <= x_dmwe;
            r_m_rwe    <= x_rwe;
            r_m_rwd    <= x_rwd;
            r_m_rdst   <= x_rdst;
        end
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: ACCESS is entered in the same edge that registers the mem op,
    // so a ready in the first ACCESS cycle gives zero extra latency
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_x_access) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!w_stall) begin
                    w_state_nxt = w_x_access ? S_ACCESS : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Memory port driven from the held M register for the whole ACCESS period
    always_comb begin
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = 32'd0;
        dm_be    = 4'b0000;
        dm_wdata = 32'd0;
        if (r_state == S_ACCESS) begin
            dm_req   = 1'b1;
            dm_we    = r_m_dmwe;
            dm_addr  = {r_m_aluout[31:2], 2'b00};
            dm_be    = is_byte_op(r_m_aluop) ? (4'b1000 >> r_m_aluout[1:0]) : 4'b1111;
            dm_wdata = is_byte_op(r_m_aluop) ? {4{r_m_rbout[7:0]}} : r_m_rbout;
        end
    end

    // ACCESS cycle counter, restarted on every entry into ACCESS
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (!w_stall && w_x_access) begin
            r_cnt <= '0;
        end else if (r_state == S_ACCESS) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    load_align u_load_align (
        .i_rdata  (dm_rdata),
        .i_offset (r_m_aluout[1:0]),
        .i_op     (r_m_aluop),
        .o_data   (w_load_data)
    );

    // Writeback register: one pulse per completed insn
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_wb_valid <= 1'b0;
            r_wb_data  <= 32'd0;
            r_wb_rdst  <= 5'd0;
            r_wb_rwe   <= 1'b0;
        end else begin
            r_wb_valid <= w_m_done;
            if (w_m_done) begin
                r_wb_data <= r_m_rwd ? w_load_data : r_m_aluout;
                r_wb_rdst <= r_m_rdst;
                r_wb_rwe  <= r_m_rwe && !w_m_misal && !w_timeout;
            end else begin
                r_wb_rwe  <= 1'b0;
            end
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            if (w_m_misal) begin
                r_misalign <= 1'b1;
            end
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign stall     = w_stall;
    assign mx_bypass = r_m_aluout;
    assign m_rdst    = r_m_rdst;
    assign m_rwe     = r_m_valid && r_m_rwe;
    assign wb_valid  = r_wb_valid;
    assign wb_data   = r_wb_data;
    assign wb_rdst   = r_wb_rdst;
    assign wb_rwe    = r_wb_rwe;
    assign misalign  = r_misalign;
    assign bus_err   = r_bus_err;

endmodule : mem_stage
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Directed self-checking bench for mem_stage (TIMEOUT=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b010011;
    localparam logic [5:0] OP_LB  = 6'b010101;
    localparam logic [5:0] OP_SB  = 6'b010111;
    localparam logic [5:0] OP_LBU = 6'b011000;

    logic        clock = 1'b0;
    logic        resetn;
    logic        x_valid;
    logic [31:0] x_aluout;
    logic [31:0] x_rbout;
    logic [5:0]  x_aluop;
    logic        x_dmwe;
    logic        x_rwe;
    logic        x_rwd;
    logic [4:0]  x_rdst;
    logic        stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic [31:0] mx_bypass;
    logic [4:0]  m_rdst;
    logic        m_rwe;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rdst;
    logic        wb_rwe;
    logic        misalign;
    logic        bus_err;

    int n_vec = 0;
    int n_err = 0;

    mem_stage #(.TIMEOUT(4)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .x_valid   (x_valid),
        .x_aluout  (x_aluout),
        .x_rbout   (x_rbout),
        .x_aluop   (x_aluop),
        .x_dmwe    (x_dmwe),
        .x_rwe     (x_rwe),
        .x_rwd     (x_rwd),
        .x_rdst    (x_rdst),
        .stall     (stall),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_be     (dm_be),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .mx_bypass (mx_bypass),
        .m_rdst    (m_rdst),
        .m_rwe     (m_rwe),
        .wb_valid  (wb_valid),
        .wb_data   (wb_data),
        .wb_rdst   (wb_rdst),
        .wb_rwe    (wb_rwe),
        .misalign  (misalign),
        .bus_err   (bus_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rb,
                         input logic [5:0] op, input logic we, input logic rwe,
                         input logic rwd, input logic [4:0] rd);
        x_valid  = v;
        x_aluout = alu;
        x_rbout  = rb;
        x_aluop  = op;
        x_dmwe   = we;
        x_rwe    = rwe;
        x_rwd    = rwd;
        x_rdst   = rd;
    endtask

    task automatic bubble();
        drive(1'b0, 32'd0, 32'd0, OP_ADD, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    // Byte load at 0x103, ready on the 3rd ACCESS cycle
    task automatic byte_load(input string tag, input logic [5:0] op, input logic [31:0] exp);
        drive(1'b1, 32'h0000_0103, 32'd0, op, 1'b0, 1'b1, 1'b1, 5'd7);
        tick();
        bubble();
        #1;
        chk({tag, "_req"},    32'(dm_req), 32'd1);
        chk({tag, "_addr"},   dm_addr, 32'h0000_0100);
        chk({tag, "_be"},     32'(dm_be), 32'h1);
        chk({tag, "_stall1"}, 32'(stall), 32'd1);
        tick();
        chk({tag, "_stall2"}, 32'(stall), 32'd1);
        tick();
        dm_ready = 1'b1;
        dm_rdata = 32'h0000_00F0;
        #1;
        chk({tag, "_stall3"}, 32'(stall), 32'd0);
        tick();
        dm_ready = 1'b0;
        dm_rdata = 32'd0;
        chk({tag, "_wbv"},    32'(wb_valid), 32'd1);
        chk({tag, "_wbd"},    wb_data, exp);
        chk({tag, "_wbrwe"},  32'(wb_rwe), 32'd1);
        chk({tag, "_wbrd"},   32'(wb_rdst), 32'd7);
        chk({tag, "_idle"},   32'(dm_req), 32'd0);
    endtask

    initial begin
        resetn   = 1'b0;
        dm_ready = 1'b0;
        dm_rdata = 32'd0;
        bubble();
        tick();
        tick();
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req",   32'(dm_req), 32'd0);
        chk("rst_wbv",   32'(wb_valid), 32'd0);
        chk("rst_mrwe",  32'(m_rwe), 32'd0);
        chk("rst_mis",   32'(misalign), 32'd0);
        chk("rst_berr",  32'(bus_err), 32'd0);
        resetn = 1'b1;
        tick();

        // Pass-through ADD
        drive(1'b1, 32'h1234_5678, 32'd0, OP_ADD, 1'b0, 1'b1, 1'b0, 5'd5);
        #1;
        chk("add_stall0", 32'(stall), 32'd0);
        tick();
        bubble();
        #1;
        chk("add_byp",    mx_bypass, 32'h1234_5678);
        chk("add_mrd",    32'(m_rdst), 32'd5);
        chk("add_mrwe",   32'(m_rwe), 32'd1);
        chk("add_stall1", 32'(stall), 32'd0);
        chk("add_req",    32'(dm_req), 32'd0);
        tick();
        chk("add_wbv",    32'(wb_valid), 32'd1);
        chk("add_wbd",    wb_data, 32'h1234_5678);
        chk("add_wbrd",   32'(wb_rdst), 32'd5);
        chk("add_wbrwe",  32'(wb_rwe), 32'd1);
        chk("add_mrwe0",  32'(m_rwe), 32'd0);
        tick();
        chk("add_wbv0",   32'(wb_valid), 32'd0);

        byte_load("lb",  OP_LB,  32'hFFFF_FFF0);
        byte_load("lbu", OP_LBU, 32'h0000_00F0);

        // LB offset 0, ready in the first ACCESS cycle
        drive(1'b1, 32'h0000_0200, 32'd0, OP_LB, 1'b0, 1'b1, 1'b1, 5'd9);
        tick();
        bubble();
        dm_ready = 1'b1;
        dm_rdata = 32'h7F00_0000;
        #1;
        chk("lb0_be",    32'(dm_be), 32'h8);
        chk("lb0_stall", 32'(stall), 32'd0);
        tick();
        dm_ready = 1'b0;
        chk("lb0_wbd",   wb_data, 32'h0000_007F);

        // SB at 0x101
        drive(1'b1, 32'h0000_0101, 32'h0000_00AB, OP_SB, 1'b1, 1'b0, 1'b0, 5'd0);
        tick();
        bubble();
        #1;
        chk("sb_req",   32'(dm_req), 32'd1);
        chk("sb_we",    32'(dm_we), 32'd1);
        chk("sb_be",    32'(dm_be), 32'h4);
        chk("sb_wdata", dm_wdata, 32'hABAB_ABAB);
        chk("sb_addr",  dm_addr, 32'h0000_0100);
        dm_ready = 1'b1;
        #1;
        chk("sb_stall", 32'(stall), 32'd0);
        tick();
        dm_ready = 1'b0;
        chk("sb_wbv",   32'(wb_valid), 32'd1);
        chk("sb_wbrwe", 32'(wb_rwe), 32'd0);

        // Misaligned LW at 0x102
        drive(1'b1, 32'h0000_0102, 32'd0, OP_LW, 1'b0, 1'b1, 1'b1, 5'd3);
        tick();
        bubble();
        #1;
        chk("mis_req",   32'(dm_req), 32'd0);
        chk("mis_stall", 32'(stall), 32'd0);
        tick();
        chk("mis_flag",  32'(misalign), 32'd1);
        chk("mis_wbv",   32'(wb_valid), 32'd1);
        chk("mis_wbrwe", 32'(wb_rwe), 32'd0);
        chk("mis_berr",  32'(bus_err), 32'd0);

        // Timeout: ready never comes
        drive(1'b1, 32'h0000_0200, 32'd0, OP_LW, 1'b0, 1'b1, 1'b1, 5'd4);
        tick();
        bubble();
        #1;
        chk("to_stall1", 32'(stall), 32'd1);
        tick();
        chk("to_stall2", 32'(stall), 32'd1);
        tick();
        chk("to_stall3", 32'(stall), 32'd1);
        chk("to_berr3",  32'(bus_err), 32'd0);
        tick();
        chk("to_stall4", 32'(stall), 32'd0);
        chk("to_req4",   32'(dm_req), 32'd1);
        tick();
        chk("to_berr",   32'(bus_err), 32'd1);
        chk("to_wbv",    32'(wb_valid), 32'd1);
        chk("to_wbrwe",  32'(wb_rwe), 32'd0);
        chk("to_req",    32'(dm_req), 32'd0);
        chk("to_stall",  32'(stall), 32'd0);

        // Reset in the middle of an access
        drive(1'b1, 32'h0000_0300, 32'd0, OP_LW, 1'b0, 1'b1, 1'b1, 5'd6);
        tick();
        bubble();
        #1;
        chk("rma_req1", 32'(dm_req), 32'd1);
        tick();
        resetn = 1'b0;
        tick();
        chk("rma_req",   32'(dm_req), 32'd0);
        chk("rma_wbv",   32'(wb_valid), 32'd0);
        chk("rma_stall", 32'(stall), 32'd0);
        chk("rma_berr",  32'(bus_err), 32'd0);
        chk("rma_mis",   32'(misalign), 32'd0);
        resetn = 1'b1;
        tick();
        tick();
        chk("rma_wbv2",  32'(wb_valid), 32'd0);

        // Pipeline runs normally after reset
        drive(1'b1, 32'hCAFE_0001, 32'd0, OP_ADD, 1'b0, 1'b1, 1'b0, 5'd1);
        tick();
        bubble();
        tick();
        chk("post_wbd",  wb_data, 32'hCAFE_0001);
        chk("post_wbv",  32'(wb_valid), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mem_stage
`default_nettype wire
